bn_deserializer: RTL and testbench

- Receiving end of the serial word stream produced by the batch-normalization layer and other sequential layers.
- Collects OUTPUT_SIZE consecutive WORD_SIZE words from a valid/ready stream into a parallel vector register.
- Presents that vector to a downstream parallel consumer, such as a dense or conv layer input, with its own valid/ready handshake.
- Helpful consumer upstream and helpful producer downstream: full throughput, one word per cycle, with no bubble between frames.

---
 rtl/bn_deserializer_pkg.sv | 11 +
 rtl/bn_deserializer_wrap.sv | 28 ++
 rtl/bn_deserializer.sv | 73 +++++++
 tb/tb_bn_deserializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bn_deserializer_pkg.sv
// Shared layer package: deserializer FSM states and counter width helper.
package bn_deserializer_pkg;

    typedef enum logic {eFILL, eFULL} deser_state_e;

    // Counter width for n states, never below one bit so n==1 still gets a real register.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bn_deserializer_wrap.sv
// Modulo counter: counts 0..MAX_VAL on en_i, wraps to 0, flags the last value.
module wrap_counter
    import bn_deserializer_pkg::*;
#(
    parameter int MAX_VAL = 3,
    parameter int WIDTH   = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_r,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    assign last_o = (count_r == MAX);

    // Wrap is explicit at MAX_VAL, not at the power-of-two rollover.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (en_i) begin
            count_r <= last_o ? '0 : count_r + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bn_deserializer.sv
// Serial-to-parallel frame collector: OUTPUT_SIZE words in, one vector out,
// with overlapped hand-off so a full-rate stream never stalls.
module bn_deserializer
    import bn_deserializer_pkg::*;
#(
    parameter int OUTPUT_SIZE = 4,
    parameter int WORD_SIZE   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    output logic                                  ready_o,
    input  logic                                  valid_i,
    input  logic [WORD_SIZE-1:0]                  data_r_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_r_o
);

    localparam int CW = clog2_min1(OUTPUT_SIZE);

    deser_state_e          state_r, state_nxt;
    logic [CW-1:0]         count_r;
    logic                  last;
    logic                  accept;
    logic [OUTPUT_SIZE-1:0] slot_we;

    assign valid_o = (state_r == eFULL);
    assign ready_o = !reset_i && ((state_r == eFILL) || ready_i);
    assign accept  = valid_i && ready_o;

    // count_r sits at 0 while full, so an overlapped accept lands in slot 0
    // and the same increment path moves the counter to 1.
    wrap_counter #(
        .MAX_VAL (OUTPUT_SIZE - 1),
        .WIDTH   (CW)
    ) u_count (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .count_r (count_r),
        .last_o  (last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= eFILL;
        else         state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            eFILL: if (accept && last) state_nxt = eFULL;
            // With a single-word frame an overlapped accept completes the next frame.
            eFULL: if (ready_i && !(accept && last)) state_nxt = eFILL;
            default: state_nxt = eFILL;
        endcase
    end

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            slot_we[i] = accept && (count_r == CW'(i));
        end
    end

    // Frame storage is deliberately not reset; valid_o gates its meaning.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (slot_we[i]) data_r_o[i] <= data_r_i;
        end
    end

endmodule

// File: tb/tb_bn_deserializer.sv
// Bench for bn_deserializer: queue-based frame model checked every cycle,
// plus hand-computed expectations, on OUTPUT_SIZE=4 and OUTPUT_SIZE=1 instances.
module tb_bn_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // OUTPUT_SIZE = 4 instance
    logic              rst4, v4, r4, ro4, vo4;
    logic [15:0]       d4;
    logic [3:0][15:0]  do4;
    // OUTPUT_SIZE = 1 instance
    logic              rst1, v1, r1, ro1, vo1;
    logic [15:0]       d1;
    logic [0:0][15:0]  do1;

    bn_deserializer #(.OUTPUT_SIZE(4), .WORD_SIZE(16)) dut4 (
        .clk_i(clk), .reset_i(rst4), .ready_o(ro4), .valid_i(v4), .data_r_i(d4),
        .valid_o(vo4), .ready_i(r4), .data_r_o(do4));

    bn_deserializer #(.OUTPUT_SIZE(1), .WORD_SIZE(16)) dut1 (
        .clk_i(clk), .reset_i(rst1), .ready_o(ro1), .valid_i(v1), .data_r_i(d1),
        .valid_o(vo1), .ready_i(r1), .data_r_o(do1));

    int checks = 0;
    int passed = 0;
    bit en_cmp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: words accepted since the last frame boundary, plus the last completed frame.
    logic [15:0]      cur4[$];
    logic [3:0][15:0] frame4;
    bit               full4 = 1'b0;
    logic [15:0]      frame1;
    bit               full1 = 1'b0;

    always @(posedge clk) begin
        if (rst4) begin
            cur4.delete();
            full4 = 1'b0;
        end else begin
            bit up;
            up = v4 && (!full4 || r4);
            if (full4 && r4) full4 = 1'b0;
            if (up) begin
                cur4.push_back(d4);
                if (cur4.size() == 4) begin
                    for (int i = 0; i < 4; i++) frame4[i] = cur4[i];
                    full4 = 1'b1;
                    cur4.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst1) begin
            full1 = 1'b0;
        end else begin
            bit up;
            up = v1 && (!full1 || r1);
            if (full1 && r1) full1 = 1'b0;
            if (up) begin
                frame1 = d1;
                full1  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("ready4", {63'd0, ro4}, {63'd0, !rst4 && (!full4 || r4)});
            chk("valid4", {63'd0, vo4}, {63'd0, full4});
            if (full4) chk("data4", do4, frame4);
            chk("ready1", {63'd0, ro1}, {63'd0, !rst1 && (!full1 || r1)});
            chk("valid1", {63'd0, vo1}, {63'd0, full1});
            if (full1) chk("data1", {48'd0, do1}, {48'd0, frame1});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] w);
        v4 = 1'b1; d4 = w; cyc();
    endtask

    int pulses;
    int sent;
    int guard;

    initial begin
        rst4 = 1'b1; v4 = 1'b1; d4 = 16'hDEAD; r4 = 1'b0;
        rst1 = 1'b1; v1 = 1'b0; d1 = 16'h0;   r1 = 1'b0;

        // Reset held two cycles with valid_i high
        cyc();
        en_cmp = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_ready_lo", {63'd0, ro4}, 64'd0);
        chk("rst_valid_lo", {63'd0, vo4}, 64'd0);
        #1;
        rst4 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, ro4}, 64'd1);
        cyc();

        // Basic fill, downstream stalled
        send4(16'h0001); send4(16'h0002); send4(16'hFFFE); send4(16'h7FFF);
        v4 = 1'b0;
        @(negedge clk);
        chk("fill_valid", {63'd0, vo4}, 64'd1);
        chk("fill_data", do4, {16'h7FFF, 16'hFFFE, 16'h0002, 16'h0001});
        chk("fill_ready_lo", {63'd0, ro4}, 64'd0);
        v4 = 1'b1; d4 = 16'hBEEF;   // offered but must not be taken while stalled
        repeat (10) cyc();
        @(negedge clk);
        chk("hold_data", do4, {16'h7FFF, 16'hFFFE, 16'h0002, 16'h0001});

        // Back-to-back frames at full rate
        #1;
        r4 = 1'b1;
        pulses = 0;
        for (int w = 1; w <= 12; w++) begin
            send4(16'(w));
            @(negedge clk);
            if (vo4) pulses++;
            #1;
        end
        chk("b2b_pulses", 64'(pulses), 64'd3);
        chk("b2b_last_frame", do4, {16'd12, 16'd11, 16'd10, 16'd9});
        v4 = 1'b0;
        cyc();

        // Upstream gaps
        sent = 0; guard = 0;
        while (sent < 8 && guard < 200) begin
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                send4(16'h0100 + 16'(sent));
                sent++;
            end else begin
                v4 = 1'b0; cyc();
            end
        end
        chk("gap_sent_all", 64'(sent), 64'd8);
        v4 = 1'b0;
        @(negedge clk);
        chk("gap_frame", do4, {16'h0107, 16'h0106, 16'h0105, 16'h0104});
        cyc();

        // Reset mid-frame discards the partial frame
        r4 = 1'b0;
        send4(16'hAAA1); send4(16'hAAA2);
        rst4 = 1'b1; v4 = 1'b1; d4 = 16'hAAA3;
        @(negedge clk);
        chk("midrst_ready_lo", {63'd0, ro4}, 64'd0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        send4(16'h000A); send4(16'h000B); send4(16'h000C); send4(16'h000D);
        v4 = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {63'd0, vo4}, 64'd1);
        chk("midrst_frame", do4, {16'h000D, 16'h000C, 16'h000B, 16'h000A});
        #1;
        r4 = 1'b1;
        cyc();

        // Single-word frames, continuous stream
        rst1 = 1'b0;
        cyc();
        r1 = 1'b1; v1 = 1'b1;
        for (int w = 16; w <= 18; w++) begin
            d1 = 16'(w);
            cyc();
            @(negedge clk);
            chk("n1_valid", {63'd0, vo1}, 64'd1);
            chk("n1_data", {48'd0, do1}, 64'(w));
            chk("n1_ready", {63'd0, ro1}, 64'd1);
            #1;
        end
        v1 = 1'b0;
        cyc();
        @(negedge clk);
        chk("n1_drain", {63'd0, vo1}, 64'd0);

        repeat (3) cyc();
        en_cmp = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
